// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-round controller and its display-side consumers.
package reaction_pkg;

    localparam int REACT_W = 14;
    localparam logic [REACT_W-1:0] BEST_RESET = 14'h3FFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_REACT = 3'd2,
        ST_DONE  = 3'd3,
        ST_FALSE = 3'd4
    } state_t;

    // Count up by one but never past lim, so the reaction counter cannot wrap.
    function automatic logic [REACT_W-1:0] sat_inc(input logic [REACT_W-1:0] v,
                                                   input logic [REACT_W-1:0] lim);
        return (v >= lim) ? lim : v + REACT_W'(1);
    endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Button/LFSR inputs and result outputs of one reaction round.
// best_ms exists only when REACTION_BEST_TIME_EN is defined.
interface reaction_round_ctrl_if
    import reaction_pkg::*;
#(
    parameter int RAND_W = 13
) ();

    logic               start;
    logic               stop;
    logic [RAND_W-1:0]  rand_val;
    logic               led;
    logic               busy;
    logic [REACT_W-1:0] react_ms;
    logic               result_valid;
    logic               timeout;
    logic               false_start;
`ifdef REACTION_BEST_TIME_EN
    logic [REACT_W-1:0] best_ms;

    modport master (
        output start, stop, rand_val,
        input  led, busy, react_ms, result_valid, timeout, false_start, best_ms
    );
    modport slave (
        input  start, stop, rand_val,
        output led, busy, react_ms, result_valid, timeout, false_start, best_ms
    );
`else
    modport master (
        output start, stop, rand_val,
        input  led, busy, react_ms, result_valid, timeout, false_start
    );
    modport slave (
        input  start, stop, rand_val,
        output led, busy, react_ms, result_valid, timeout, false_start
    );
`endif

endinterface

// File: rtl/reaction_round_ctrl_ms_tick_gen.sv
// Millisecond strobe: a one-cycle tick every CLKS_PER_MS clocks, restartable with clr.
module ms_tick_gen #(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == TC);

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// One reaction-time round per start press: random delay, LED, then ms count until stop or timeout.
// Best-time tracking is built only when REACTION_BEST_TIME_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | after reset, waiting for a start edge
// ST_WAIT  | counting down the random delay, LED off
// ST_REACT | LED on, counting ms until stop or saturation
// ST_DONE  | result (or timeout) held for the display
// ST_FALSE | stop pressed before the LED, false start held
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int CLKS_PER_MS  = 50000,
    parameter int RAND_W       = 13,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_REACT_MS = 9999
) (
    input  logic                 clk,
    input  logic                 reset,
    reaction_round_ctrl_if.slave bus
);

    localparam logic [RAND_W-1:0]  MIN_D = RAND_W'(MIN_DELAY_MS);
    localparam logic [RAND_W-1:0]  D_ONE = RAND_W'(1);
    localparam logic [REACT_W-1:0] MAX_R = REACT_W'(MAX_REACT_MS);

    state_t             r_state;
    logic               r_start_q;
    logic [RAND_W-1:0]  r_delay_cnt;
    logic [REACT_W-1:0] r_react_cnt;
    logic [REACT_W-1:0] r_react_ms;
    logic               r_led;
    logic               r_busy;
    logic               r_valid;
    logic               r_timeout;
    logic               r_false_start;

    logic               w_start_edge;
    logic               w_launch;
    logic               w_arm;
    logic               w_tick;
    logic [RAND_W-1:0]  w_delay_init;
    logic [REACT_W-1:0] w_react_nxt;

    assign w_start_edge = bus.start & ~r_start_q;
    assign w_launch     = w_start_edge &&
                          (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_FALSE);
    // Final delay tick with no stop: the prescaler restarts so REACT gets full-length ms.
    assign w_arm        = (r_state == ST_WAIT) && !bus.stop && w_tick && (r_delay_cnt == D_ONE);
    assign w_delay_init = (bus.rand_val < MIN_D) ? MIN_D : bus.rand_val;
    assign w_react_nxt  = sat_inc(r_react_cnt, MAX_R);

    ms_tick_gen #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (w_launch | w_arm),
        .tick (w_tick)
    );

`ifdef REACTION_BEST_TIME_EN
    logic [REACT_W-1:0] r_best_ms;
    assign bus.best_ms = r_best_ms;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_start_q     <= 1'b0;
            r_delay_cnt   <= '0;
            r_react_cnt   <= '0;
            r_react_ms    <= '0;
            r_led         <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
            r_false_start <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
            r_best_ms     <= BEST_RESET;
`endif
        end else begin
            r_start_q <= bus.start;
            case (r_state)
                ST_IDLE, ST_DONE, ST_FALSE: begin
                    if (w_start_edge) begin
                        r_state       <= ST_WAIT;
                        r_delay_cnt   <= w_delay_init;
                        r_react_cnt   <= '0;
                        r_busy        <= 1'b1;
                        r_valid       <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_false_start <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.stop) begin
                        r_state       <= ST_FALSE;
                        r_false_start <= 1'b1;
                        r_busy        <= 1'b0;
                    end else if (w_tick) begin
                        r_delay_cnt <= r_delay_cnt - D_ONE;
                        if (r_delay_cnt == D_ONE) begin
                            r_state <= ST_REACT;
                            r_led   <= 1'b1;
                        end
                    end
                end
                ST_REACT: begin
                    // stop has priority, so a tick landing with it is not counted
                    if (bus.stop) begin
                        r_state    <= ST_DONE;
                        r_react_ms <= r_react_cnt;
                        r_valid    <= 1'b1;
                        r_led      <= 1'b0;
                        r_busy     <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
                        if (r_react_cnt < r_best_ms) begin
                            r_best_ms <= r_react_cnt;
                        end
`endif
                    end else if (w_tick) begin
                        r_react_cnt <= w_react_nxt;
                        if (w_react_nxt == MAX_R) begin
                            r_state    <= ST_DONE;
                            r_react_ms <= MAX_R;
                            r_timeout  <= 1'b1;
                            r_valid    <= 1'b1;
                            r_led      <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.led          = r_led;
    assign bus.busy         = r_busy;
    assign bus.react_ms     = r_react_ms;
    assign bus.result_valid = r_valid;
    assign bus.timeout      = r_timeout;
    assign bus.false_start  = r_false_start;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Self-checking bench for reaction_round_ctrl with a 4-clock ms, 3 ms delay floor and 20 ms limit.
// best_ms checks are compiled in only when REACTION_BEST_TIME_EN is defined.
module tb_reaction_round_ctrl;

    localparam int CLKS      = 4;
    localparam int MIN_D     = 3;
    localparam int MAX_R     = 20;
    localparam int BEST_INIT = 16383;

    typedef struct {
        int rv;
        int ws;
        int rs;
        int e_led;
        int e_react;
        bit e_to;
        bit e_fs;
        int e_best;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   mdl_best;
    vec_t tbl[9];

    reaction_round_ctrl_if #(.RAND_W(13)) bus ();

    reaction_round_ctrl #(
        .CLKS_PER_MS (CLKS),
        .RAND_W      (13),
        .MIN_DELAY_MS(MIN_D),
        .MAX_REACT_MS(MAX_R)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ws > 0: stop is sampled ws cycles after WAIT entry. Otherwise rs in 1..MAX_R*CLKS gives
    // the cycle after REACT entry at which stop is sampled; anything else lets the round time out.
    task automatic run_round(input string tag, input int rv, input int ws, input int rs,
                             input int e_led, input int e_react, input bit e_to,
                             input bit e_fs, input int e_best);
        int n;
        bus.rand_val = 13'(rv);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, " busy_at_entry"}, bus.busy, 1);
        chk({tag, " false_clr_at_entry"}, bus.false_start, 0);
        chk({tag, " valid_clr_at_entry"}, bus.result_valid, 0);
        if (e_fs) begin
            repeat (ws - 1) step();
            bus.stop = 1'b1;
            step();
            bus.stop = 1'b0;
            chk({tag, " false_start"}, bus.false_start, 1);
            chk({tag, " fs_busy"}, bus.busy, 0);
            chk({tag, " fs_valid"}, bus.result_valid, 0);
            repeat (e_led + 4) step();
            chk({tag, " fs_led_stays_off"}, bus.led, 0);
            chk({tag, " fs_hold"}, bus.false_start, 1);
`ifdef REACTION_BEST_TIME_EN
            chk({tag, " fs_best"}, bus.best_ms, e_best);
`endif
        end else begin
            n = 0;
            while (bus.led !== 1'b1 && n < e_led + 8) begin
                step();
                n++;
            end
            chk({tag, " led_delay"}, n, e_led);
            chk({tag, " busy_react"}, bus.busy, 1);
            if (rs > 0 && rs <= MAX_R * CLKS) begin
                repeat (rs - 1) step();
                chk({tag, " valid_before_stop"}, bus.result_valid, 0);
                bus.stop = 1'b1;
                step();
                bus.stop = 1'b0;
            end else begin
                repeat (MAX_R * CLKS - 1) step();
                chk({tag, " valid_before_timeout"}, bus.result_valid, 0);
                chk({tag, " led_before_timeout"}, bus.led, 1);
                step();
            end
            chk({tag, " result_valid"}, bus.result_valid, 1);
            chk({tag, " react_ms"}, bus.react_ms, e_react);
            chk({tag, " timeout"}, bus.timeout, e_to);
            chk({tag, " led_off"}, bus.led, 0);
            chk({tag, " busy_off"}, bus.busy, 0);
`ifdef REACTION_BEST_TIME_EN
            chk({tag, " best_ms"}, bus.best_ms, e_best);
`endif
            repeat (3) step();
            chk({tag, " valid_hold"}, bus.result_valid, 1);
            chk({tag, " react_hold"}, bus.react_ms, e_react);
        end
    endtask

    initial begin
        int n;
        //          rv ws  rs  led react to fs best
        tbl[0] = '{5,  0,  37, 20, 9,    0, 0, 9};
        tbl[1] = '{0,  0,  17, 12, 4,    0, 0, 4};
        tbl[2] = '{1,  0,  25, 12, 6,    0, 0, 4};
        tbl[3] = '{2,  0,  0,  12, 20,   1, 0, 4};
        tbl[4] = '{4,  16, 0,  16, 0,    0, 1, 4};
        tbl[5] = '{3,  1,  0,  12, 0,    0, 1, 4};
        tbl[6] = '{3,  0,  80, 12, 19,   0, 0, 4};
        tbl[7] = '{8,  0,  29, 32, 7,    0, 0, 4};
        tbl[8] = '{6,  0,  4,  24, 0,    0, 0, 0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.rand_val = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        chk("idle led", bus.led, 0);
        chk("idle busy", bus.busy, 0);
        chk("idle react_ms", bus.react_ms, 0);
        chk("idle valid", bus.result_valid, 0);
        chk("idle timeout", bus.timeout, 0);
        chk("idle false_start", bus.false_start, 0);
`ifdef REACTION_BEST_TIME_EN
        chk("idle best_ms", bus.best_ms, BEST_INIT);
`endif

        for (int i = 0; i < 9; i++) begin
            run_round($sformatf("vec%0d", i), tbl[i].rv, tbl[i].ws, tbl[i].rs, tbl[i].e_led,
                      tbl[i].e_react, tbl[i].e_to, tbl[i].e_fs, tbl[i].e_best);
        end

        // start edges while busy must not restart the delay or the count
        bus.rand_val = 13'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.rand_val = 13'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 5;
        while (bus.led !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("busy_start led_delay", n, 20);
        repeat (2) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("busy_start react_ms", bus.react_ms, 3);
        chk("busy_start valid", bus.result_valid, 1);

        // reset in the middle of REACT
        bus.rand_val = 13'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (bus.led !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("midreset led_delay", n, 12);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset led", bus.led, 0);
        chk("midreset busy", bus.busy, 0);
        chk("midreset valid", bus.result_valid, 0);
`ifdef REACTION_BEST_TIME_EN
        chk("midreset best_ms", bus.best_ms, BEST_INIT);
`endif
        repeat (8) step();
        chk("midreset stays idle", bus.busy, 0);

        mdl_best = BEST_INIT;
        for (int i = 0; i < 25; i++) begin
            int rv, ws, rs, d, e_led, e_react;
            bit e_to, e_fs;
            rv = $urandom_range(0, 10);
            d = (rv < MIN_D) ? MIN_D : rv;
            e_led = d * CLKS;
            ws = ($urandom_range(0, 3) == 0) ? $urandom_range(1, e_led) : 0;
            rs = $urandom_range(0, MAX_R * CLKS + 6);
            e_fs = (ws != 0);
            e_to = 1'b0;
            e_react = 0;
            if (!e_fs) begin
                if (rs == 0 || rs > MAX_R * CLKS) begin
                    e_to = 1'b1;
                    e_react = MAX_R;
                end else begin
                    e_react = (rs - 1) / CLKS;
                end
                if (!e_to && e_react < mdl_best) mdl_best = e_react;
            end
            run_round($sformatf("rnd%0d", i), rv, ws, rs, e_led, e_react, e_to, e_fs, mdl_best);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
- Consumes the 13-bit pseudo-random value from the upstream LFSR stage and runs one reaction-time round per start press.
- Sequence: random delay in ms, then LED on, then count ms until the stop button or timeout.
- Result feeds the downstream BCD / seven-segment display stage.
- Sits between the LFSR and the display driver in the Project 2 reaction timer.

Parameters:
- CLKS_PER_MS, 50000, clk cycles per 1 ms tick (50 MHz board clock)
- RAND_W, 13, width of random input
- MIN_DELAY_MS, 1000, floor applied to random delay
- MAX_REACT_MS, 9999, reaction count saturation / timeout value (4 display digits)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start button, already debounced, level; block edge-detects internally
- stop  in  1  reaction button, already debounced, level
- rand_val  in  RAND_W  current LFSR output; sampled on the start edge only
- led  out  1  stimulus LED, high in REACT
- busy  out  1  high in WAIT and REACT
- react_ms  out  14  reaction time in ms; valid when result_valid is high
- result_valid  out  1  high in DONE
- timeout  out  1  high in DONE if the count saturated
- false_start  out  1  high in FALSE
- best_ms  out  14  best (lowest) non-timeout time (only with feature)

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; all outputs 0, except best_ms = 14'h3FFF.
- Reset mid-round aborts to IDLE with no result retained, except best_ms is also cleared.
- start_edge = start & ~start_q, where start_q is registered. stop is level-sampled.
- States: IDLE, WAIT, REACT, DONE, FALSE.
- IDLE / DONE / FALSE, on start_edge:
  - delay_cnt <= max(rand_val, MIN_DELAY_MS).
  - react_cnt <= 0, tick prescaler <= 0.
  - Clear result_valid, timeout and false_start.
  - Go to WAIT. busy is high the next cycle.
- WAIT:
  - On each ms tick, decrement delay_cnt.
  - On the tick where delay_cnt == 1, go to REACT: led = 1 and prescaler cleared.
  - stop high in any WAIT cycle goes to FALSE, including the same cycle as the final tick (stop wins).
  - A start edge is ignored.
- REACT:
  - On each tick, react_cnt++.
  - If react_cnt reaches MAX_REACT_MS, go to DONE with timeout = 1 and react_ms = MAX_REACT_MS.
  - stop sampled high in cycle N gives react_ms = react_cnt and result_valid = 1 at N+1. A tick in the same cycle is not counted.
  - led drops on exit.
- Tick: the prescaler counts 0..CLKS_PER_MS-1 and ticks at terminal count. It is cleared on WAIT and REACT entry, so the first tick is exactly CLKS_PER_MS cycles after entry.
- Widths:
  - delay_cnt is RAND_W bits; a 0 random value is covered by the floor.
  - react_cnt is 14 bits and never wraps (saturates).
- DONE / FALSE hold their outputs indefinitely until start_edge or reset.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined:
  - best_ms port exists.
  - On DONE entry with timeout = 0 and react_ms < best_ms, best_ms <= react_ms, visible the same cycle as result_valid.
  - Timeouts and false starts never update best_ms. Equal times leave it unchanged.
- Undefined: best_ms port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package reaction_pkg:
  - State encoding constants (IDLE = 0, WAIT = 1, REACT = 2, DONE = 3, FALSE = 4; 3 bits).
  - REACT_W = 14.
  - BEST_RESET = 14'h3FFF.
- One natural sub-module, ms_tick_gen (parameter CLKS_PER_MS):
  - Inputs clk, reset, clr.
  - Output tick, a single-cycle pulse.
  - Reused by the display multiplexer.

Test Plan (CLKS_PER_MS = 4, MIN_DELAY_MS = 3, MAX_REACT_MS = 20):
- Reset, then idle 10 cycles -> all outputs 0, busy 0, best_ms = 3FFF.
- rand_val = 5, start pulse -> busy next cycle; led rises exactly 20 cycles after WAIT entry; stop held after 7 ticks -> react_ms = 7, result_valid one cycle after stop, led 0.
- rand_val = 0 -> floor applied; led after 12 cycles. rand_val = 1 gives the same 12-cycle delay.
- stop asserted during WAIT, including the final-tick cycle -> false_start = 1, led never rises, result_valid 0; a later start edge clears false_start and starts a new round.
- No stop in REACT -> after 20 ticks (80 cycles): timeout = 1, react_ms = 20, result_valid = 1; with REACTION_BEST_TIME_EN, best_ms is unchanged by the timeout.
- Rounds with times 9, then 4, then 6 -> best_ms 9, 4, 4. Reset asserted mid-REACT -> IDLE next cycle, led 0, best_ms = 3FFF. A start edge while busy has no effect.
